// File: rtl/press_report_sequencer_if.sv
// Byte-wide valid/ready stream from the report sequencer to the UART transmitter.
// Master drives data/valid and holds them until the slave's ready completes the transfer.
interface press_report_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/press_report_sequencer.sv
// Press -> "BTN=<hex>\r\n" report sequencer; first byte valid 2 cycles after a press.
// Stalls on tx_ready low with data held; mid-message presses coalesce into one follow-up report.
module press_report_sequencer #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                     clk_12m,
  input  logic                     rst_n,
  input  logic                     pressed,
  input  logic [COUNT_WIDTH-1:0]   count,
  press_report_sequencer_if.master tx,
  output logic                     busy,
  output logic [7:0]               drop_count
);
  localparam int DIGITS  = COUNT_WIDTH / 4;
  localparam int MSG_LEN = DIGITS + 6;
  localparam int IDX_W   = $clog2(MSG_LEN);

  typedef enum logic [1:0] {IDLE, ARM, SEND} state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   pending_q, pending_d;
  logic [7:0]             drop_q, drop_d;
  logic                   xfer, last_byte;
  logic [3:0]             nib;
  logic [7:0]             byte_sel;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign xfer      = (state_q == SEND) && tx.tx_ready;
  assign last_byte = (idx_q == IDX_W'(MSG_LEN - 1));

  // Digit bytes occupy indices 4..DIGITS+3, most significant nibble first.
  always_comb begin
    nib = 4'h0;
    for (int d = 0; d < DIGITS; d++) begin
      if (int'(idx_q) == d + 4) nib = snap_q[4*(DIGITS-1-d) +: 4];
    end
    if (idx_q == IDX_W'(0))                byte_sel = 8'h42;
    else if (idx_q == IDX_W'(1))           byte_sel = 8'h54;
    else if (idx_q == IDX_W'(2))           byte_sel = 8'h4E;
    else if (idx_q == IDX_W'(3))           byte_sel = 8'h3D;
    else if (idx_q == IDX_W'(MSG_LEN - 2)) byte_sel = 8'h0D;
    else if (idx_q == IDX_W'(MSG_LEN - 1)) byte_sel = 8'h0A;
    else                                   byte_sel = hex_char(nib);
  end

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    drop_d    = drop_q;

    // A press during ARM is not reflected in that ARM's snapshot, so it re-arms pending.
    if (state_q == ARM) begin
      pending_d = pressed;
    end else if (state_q == SEND && pressed) begin
      if (!pending_q)            pending_d = 1'b1;
      else if (drop_q != 8'hFF)  drop_d    = drop_q + 8'd1;
    end

    case (state_q)
      IDLE: if (pressed) state_d = ARM;
      ARM: begin
        snap_d  = count;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (last_byte) state_d = pending_d ? ARM : IDLE;
          else           idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_12m) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      drop_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  assign tx.tx_valid = (state_q == SEND);
  assign tx.tx_data  = (state_q == SEND) ? byte_sel : 8'h00;
  assign busy        = (state_q != IDLE);
  assign drop_count  = drop_q;
endmodule

// File: tb/tb_press_report_sequencer.sv
// Bench for press_report_sequencer: table of single reports plus hand-written coalescing,
// saturation, reset and back-to-back sequences, with a byte scoreboard on the TX stream.
module tb_press_report_sequencer;
  logic        clk_12m = 1'b0;
  logic        rst_n;
  logic        pressed;
  logic [15:0] count;
  logic        busy;
  logic [7:0]  drop_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_q[$];
  bit         hold_q = 1'b0;
  logic [7:0] hold_dat;
  logic [7:0] exp_b;

  typedef struct {
    logic [15:0] cnt;
    bit          rnd;
    logic [31:0] hex;
  } vec_t;

  vec_t vecs[5];

  press_report_sequencer_if tx_if();

  press_report_sequencer #(.COUNT_WIDTH(16)) dut (
    .clk_12m   (clk_12m),
    .rst_n     (rst_n),
    .pressed   (pressed),
    .count     (count),
    .tx        (tx_if),
    .busy      (busy),
    .drop_count(drop_count)
  );

  always #5 clk_12m = ~clk_12m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Byte monitor: transfers popped against the scoreboard, held data checked for stability.
  always @(negedge clk_12m) begin
    if (hold_q) begin
      chk("hold_valid", 32'(tx_if.tx_valid), 32'd1);
      chk("hold_data", 32'(tx_if.tx_data), 32'(hold_dat));
    end
    hold_q   = tx_if.tx_valid && !tx_if.tx_ready && rst_n;
    hold_dat = tx_if.tx_data;
    if (tx_if.tx_valid && tx_if.tx_ready && rst_n) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %0h want none", tx_if.tx_data);
      end else begin
        exp_b = sb_q.pop_front();
        chk("byte", 32'(tx_if.tx_data), 32'(exp_b));
      end
    end
  end

  // One cycle: the press of the cycle just ended bumps the counter, as the debouncer would.
  task automatic tick();
    @(posedge clk_12m);
    #1;
    if (pressed) count = count + 16'd1;
    pressed = 1'b0;
  endtask

  task automatic push_msg(input logic [31:0] hex);
    sb_q.push_back(8'h42);
    sb_q.push_back(8'h54);
    sb_q.push_back(8'h4E);
    sb_q.push_back(8'h3D);
    for (int i = 0; i < 4; i++) sb_q.push_back(hex[31-8*i -: 8]);
    sb_q.push_back(8'h0D);
    sb_q.push_back(8'h0A);
  endtask

  task automatic run_msg(input logic [15:0] cnt, input bit rnd, input logic [31:0] hex,
                         input string tag);
    int first_v = -1;
    int idle_at = -1;
    int lows    = 0;
    int vcyc    = 0;
    count          = cnt - 16'd1;
    tx_if.tx_ready = 1'b1;
    pressed        = 1'b1;
    push_msg(hex);
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (tx_if.tx_valid && first_v < 0) first_v = n;
      if (!busy) begin
        idle_at = n;
        break;
      end
      tx_if.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_if.tx_valid) begin
        vcyc++;
        if (!tx_if.tx_ready) lows++;
      end
    end
    chk({tag, "_first_valid"}, 32'(first_v), 32'd2);
    chk({tag, "_idle_at"}, 32'(idle_at), 32'(12 + lows));
    chk({tag, "_length"}, 32'(vcyc), 32'(10 + lows));
    chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int n_last, second_v, idle_at, xf;
    logic busy12, valid12, valid13;

    vecs[0] = '{16'h0001, 1'b0, "0001"};
    vecs[1] = '{16'hBEEF, 1'b1, "BEEF"};
    vecs[2] = '{16'hA5C3, 1'b1, "A5C3"};
    vecs[3] = '{16'h09AF, 1'b0, "09AF"};
    vecs[4] = '{16'hFFFF, 1'b1, "FFFF"};

    rst_n          = 1'b0;
    pressed        = 1'b0;
    count          = 16'h0000;
    tx_if.tx_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("rst_data", 32'(tx_if.tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_msg(vecs[i].cnt, vecs[i].rnd, vecs[i].hex, $sformatf("vec%0d", i));
    chk("drop_after_vecs", 32'(drop_count), 32'd0);

    // Three presses mid-message coalesce into a single follow-up carrying 0x0007.
    count          = 16'h0003;
    tx_if.tx_ready = 1'b1;
    pressed        = 1'b1;
    push_msg("0004");
    push_msg("0007");
    n_last = -1; second_v = -1; idle_at = -1; xf = 0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (n_last > 0 && second_v < 0 && tx_if.tx_valid) second_v = n;
      if (!busy) begin
        idle_at = n;
        break;
      end
      if (n == 4 || n == 6 || n == 8) pressed = 1'b1;
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        xf++;
        if (xf == 10) n_last = n;
      end
    end
    chk("coal_last_xfer", 32'(n_last), 32'd11);
    chk("coal_second_valid", 32'(second_v), 32'(n_last + 2));
    chk("coal_idle_at", 32'(idle_at), 32'(n_last + 12));
    chk("coal_drop", 32'(drop_count), 32'd2);
    chk("coal_sb_empty", 32'(sb_q.size()), 32'd0);

    // 300 presses with the UART stalled: drop counter saturates, one follow-up only.
    count          = 16'h0010;
    tx_if.tx_ready = 1'b0;
    pressed        = 1'b1;
    push_msg("0011");
    push_msg("013D");
    tick();
    for (int i = 0; i < 300; i++) begin
      pressed = 1'b1;
      tick();
      tick();
    end
    chk("sat_drop", 32'(drop_count), 32'd255);
    chk("sat_busy", 32'(busy), 32'd1);
    chk("sat_first_byte", 32'(tx_if.tx_data), 32'h42);
    tx_if.tx_ready = 1'b1;
    for (int n = 0; n < 100 && busy; n++) tick();
    chk("sat_idle", 32'(busy), 32'd0);
    chk("sat_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset after byte index 4 abandons the message.
    count          = 16'h0041;
    tx_if.tx_ready = 1'b1;
    pressed        = 1'b1;
    push_msg("0042");
    for (int n = 1; n <= 7; n++) tick();
    rst_n          = 1'b0;
    tx_if.tx_ready = 1'b0;
    chk("mid_remaining", 32'(sb_q.size()), 32'd5);
    tick();
    chk("mid_rst_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("mid_rst_data", 32'(tx_if.tx_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    sb_q.delete();
    tx_if.tx_ready = 1'b1;
    for (int n = 0; n < 15; n++) tick();
    chk("post_rst_quiet", 32'(busy), 32'd0);
    run_msg(16'h1234, 1'b0, "1234", "after_rst");

    // Press coincident with the final 0x0A transfer chains straight into a new report.
    count          = 16'h00FF;
    tx_if.tx_ready = 1'b1;
    pressed        = 1'b1;
    push_msg("0100");
    push_msg("0101");
    busy12 = 1'b0; valid12 = 1'b1; valid13 = 1'b0; idle_at = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n == 12) begin
        busy12  = busy;
        valid12 = tx_if.tx_valid;
      end
      if (n == 13) valid13 = tx_if.tx_valid;
      if (!busy) begin
        idle_at = n;
        break;
      end
      if (n == 11) pressed = 1'b1;
    end
    chk("edge_busy_arm", 32'(busy12), 32'd1);
    chk("edge_gap_valid", 32'(valid12), 32'd0);
    chk("edge_next_valid", 32'(valid13), 32'd1);
    chk("edge_idle_at", 32'(idle_at), 32'd23);
    chk("edge_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("edge_drop", 32'(drop_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/press_report_sequencer.md
# press_report_sequencer

Controller that turns button-press events into ASCII report messages on a byte-wide valid/ready stream feeding the UART transmitter. Sits between the debounced press pulse and counter value on one side and the UART TX byte interface on the other. Captures the counter value after each press, formats it as uppercase hex, and sequences the bytes out. Presses arriving mid-message are coalesced into one follow-up report and counted when lost.

## Interface
- COUNT_WIDTH, 16, width of the counter value; must be a multiple of 4; DIGITS = COUNT_WIDTH/4
- clk_12m  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- pressed  in  1  single-cycle press pulse from the debouncer
- count  in  COUNT_WIDTH  press counter value; updates the cycle after `pressed`
- tx_data  out  8  message byte to the UART TX
- tx_valid  out  1  tx_data holds a byte to transfer
- tx_ready  in  1  UART TX accepts the byte this cycle
- busy  out  1  high while a report is armed or being sent
- drop_count  out  8  saturating count of presses lost to coalescing

## Operation
- Message: "BTN=" + DIGITS hex digits, MSB nibble first + 0x0D + 0x0A. Total length DIGITS+6 bytes; 10 bytes at default.
- Hex encode: nibble 0–9 → 0x30+n; nibble 10–15 → 0x41+(n−10); uppercase only.
- States:
  - IDLE: tx_valid=0, busy=0. `pressed` → ARM.
  - ARM: one cycle. Latches `count` into snapshot register, clears pending, byte index=0 → SEND.
  - SEND: tx_valid=1, tx_data=byte[index].
    - Transfer occurs when tx_valid && tx_ready; index increments on each transfer.
    - Transfer of the last byte → ARM if pending is set after that cycle's update, else IDLE.
- Pending/coalescing, evaluated every cycle state≠IDLE:
  - `pressed` with pending=0 → pending=1.
  - `pressed` with pending=1 → drop_count+1, saturating at 255.
  - ARM clears pending. A `pressed` in the same ARM cycle sets pending again (set wins).
- Follow-up report carries the count value sampled in its own ARM cycle. It therefore reflects all coalesced presses.
- Handshake rules:
  - tx_valid never depends combinationally on tx_ready.
  - Once tx_valid rises, tx_data and tx_valid stay stable until the transfer.
  - No bubble between bytes of one message when tx_ready stays high.
- busy = (state ≠ IDLE). Registered, driven from the state register.
- Snapshot is taken only in ARM; changes on `count` during SEND do not affect the message in flight.
- Reset (rst_n=0 at a rising edge), at any point including mid-message:
  - state=IDLE; tx_valid=0, tx_data=0x00, busy=0, drop_count=0, pending=0, snapshot=0.
  - Any partial message is abandoned, not resumed.

## Timing
- `pressed` in cycle N (IDLE) → ARM in N+1 → snapshot captures the post-increment count in N+1.
- First tx_valid ('B') in cycle N+2. Latency from press to first byte: 2 cycles.
- With tx_ready held high: bytes in N+2..N+DIGITS+7; IDLE (busy=0) in N+DIGITS+8.
- Back-to-back reports: last-byte transfer in cycle M → ARM in M+1 → next 'B' valid in M+2. Minimum message gap: 1 idle tx_valid cycle.
- tx_ready low for K cycles during SEND stretches the message by exactly K cycles; no byte is skipped or repeated.
- `pressed` coincident with the last-byte transfer counts as mid-message: pending is set → ARM follows.
- drop_count updates the cycle after the offending `pressed`.

## Test plan
- Reset, then a single press with count going 0x0000→0x0001, tx_ready=1 → bytes 42 54 4E 3D 30 30 30 31 0D 0A. First valid 2 cycles after `pressed`; busy low 12 cycles after `pressed`; drop_count=0.
- count=0xBEEF with a random tx_ready pattern (≈50% duty) → bytes 42 54 4E 3D 42 45 45 46 0D 0A. tx_data stable while valid && !ready; message length equals 10 + number of ready-low cycles in SEND.
- Three presses during one message, count reaching 0x0007 → exactly one follow-up message "BTN=0007\r\n" starting 2 cycles after the first message's last transfer; drop_count=2.
- 300 presses while tx_ready is held low → drop_count saturates at 255. After tx_ready returns high, only the current message plus one follow-up are sent.
- rst_n low for one cycle after byte index 4 of a message → tx_valid=0 next cycle, all outputs at reset values, no further bytes. The next press produces a complete message from 'B'.
- `pressed` in the same cycle as the final 0x0A transfer → busy stays high, ARM next cycle, new 'B' valid 2 cycles after that transfer.
